// File: rtl/shifter_serializer.sv
// Parallel-to-serial transmitter: valid/ready word in, MSB-first bit stream out with per-bit strobes.
// Optional even-parity trailer bit when SHIFTER_SERIALIZER_PARITY_EN is defined.
module shifter_serializer #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned DIV   = 1,
    parameter int unsigned GAP   = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] word_i,
    input  logic             word_val_i,
    output logic             word_rdy_o,
    output logic             data_o,
    output logic             data_val_o,
    output logic             first_o,
    output logic             last_o,
    output logic             busy_o
);
`ifdef SHIFTER_SERIALIZER_PARITY_EN
    localparam int unsigned FRAME = WIDTH + 1;
`else
    localparam int unsigned FRAME = WIDTH;
`endif
    localparam int unsigned BW       = $clog2(WIDTH + 1);
    localparam logic [BW-1:0] BIT_LAST = BW'(FRAME - 1);
    localparam logic [15:0]   DIV_LAST = 16'(DIV - 1);
    localparam logic [15:0]   GAP_LAST = (GAP == 0) ? 16'd0 : 16'(GAP - 1);

    typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_GAP} state_t;

    state_t           state_q, state_d;
    logic [FRAME-1:0] shreg_q, shreg_d;
    logic [BW-1:0]    bit_q, bit_d;
    logic [15:0]      div_q, div_d;
    logic [15:0]      gap_q, gap_d;
    logic             rdy_q, rdy_d;
    logic             data_q, data_d;
    logic             val_q, val_d;
    logic             first_q, first_d;
    logic             last_q, last_d;
    logic             busy_q, busy_d;
    logic             accept;
    logic [FRAME-1:0] capture;

`ifdef SHIFTER_SERIALIZER_PARITY_EN
    assign capture = {word_i, ^word_i};
`else
    assign capture = word_i;
`endif

    assign accept = word_val_i && rdy_q;

    // Next state; outputs are derived from the next state so they register in step with it.
    always_comb begin
        state_d = state_q;
        shreg_d = shreg_q;
        bit_d   = bit_q;
        div_d   = div_q;
        gap_d   = gap_q;
        unique case (state_q)
            S_SHIFT: begin
                if (div_q == DIV_LAST) begin
                    div_d = 16'd0;
                    if (bit_q == BIT_LAST) begin
                        state_d = (GAP == 0) ? S_IDLE : S_GAP;
                        bit_d   = '0;
                        gap_d   = 16'd0;
                    end else begin
                        shreg_d = shreg_q << 1;
                        bit_d   = bit_q + BW'(1);
                    end
                end else begin
                    div_d = div_q + 16'd1;
                end
            end
            S_GAP: begin
                if (gap_q == GAP_LAST) begin
                    state_d = S_IDLE;
                    gap_d   = 16'd0;
                end else begin
                    gap_d = gap_q + 16'd1;
                end
            end
            default: ;
        endcase
        if (accept) begin
            state_d = S_SHIFT;
            shreg_d = capture;
            bit_d   = '0;
            div_d   = 16'd0;
        end
        data_d  = (state_d == S_SHIFT) && shreg_d[FRAME-1];
        val_d   = (state_d == S_SHIFT) && (div_d == 16'd0);
        first_d = val_d && (bit_d == '0);
        last_d  = val_d && (bit_d == BIT_LAST);
        busy_d  = (state_d != S_IDLE);
        rdy_d   = (state_d == S_IDLE) ||
                  ((GAP == 0) && (state_d == S_SHIFT) && (div_d == DIV_LAST) && (bit_d == BIT_LAST));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            shreg_q <= '0;
            bit_q   <= '0;
            div_q   <= 16'd0;
            gap_q   <= 16'd0;
            rdy_q   <= 1'b1;
            data_q  <= 1'b0;
            val_q   <= 1'b0;
            first_q <= 1'b0;
            last_q  <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            shreg_q <= shreg_d;
            bit_q   <= bit_d;
            div_q   <= div_d;
            gap_q   <= gap_d;
            rdy_q   <= rdy_d;
            data_q  <= data_d;
            val_q   <= val_d;
            first_q <= first_d;
            last_q  <= last_d;
            busy_q  <= busy_d;
        end
    end

    assign word_rdy_o = rdy_q;
    assign data_o     = data_q;
    assign data_val_o = val_q;
    assign first_o    = first_q;
    assign last_o     = last_q;
    assign busy_o     = busy_q;
endmodule

// File: tb/tb_shifter_serializer.sv
// Bench for shifter_serializer: three configurations share one stimulus stream and are checked
// every cycle against a timeline model, plus hand-computed expectations at key cycles.
module tb_shifter_serializer;
    localparam int W = 8;
`ifdef SHIFTER_SERIALIZER_PARITY_EN
    localparam int FRAME = W + 1;
`else
    localparam int FRAME = W;
`endif
    localparam int ND = 3;

    logic         clk = 1'b0;
    logic         rst;
    logic [W-1:0] word;
    logic         word_val;
    logic         rdy_o   [ND];
    logic         data_o  [ND];
    logic         val_o   [ND];
    logic         first_o [ND];
    logic         last_o  [ND];
    logic         busy_o  [ND];

    always #5 clk = ~clk;

    // dut0: DIV=1 GAP=0, dut1: DIV=3 GAP=0, dut2: DIV=1 GAP=4
    for (genvar g = 0; g < ND; g++) begin : g_dut
        shifter_serializer #(
            .WIDTH(W),
            .DIV  ((g == 1) ? 3 : 1),
            .GAP  ((g == 2) ? 4 : 0)
        ) u_dut (
            .clk       (clk),
            .rst       (rst),
            .word_i    (word),
            .word_val_i(word_val),
            .word_rdy_o(rdy_o[g]),
            .data_o    (data_o[g]),
            .data_val_o(val_o[g]),
            .first_o   (first_o[g]),
            .last_o    (last_o[g]),
            .busy_o    (busy_o[g])
        );
    end

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    bit chk_en   = 1'b0;

    // Model state: accept cycle and captured frame per DUT.
    bit               act  [ND];
    int               tacc [ND];
    logic [FRAME-1:0] frm  [ND];

    // Directed-test anchor cycles (cycle in which the word was presented and accepted).
    int ta5 = -1000, tbb = -1000, tgp = -1000, tmr = -1000, tpa = -1000, tpb = -1000;

    function automatic int div_of(input int i);
        return (i == 1) ? 3 : 1;
    endfunction

    function automatic int gap_of(input int i);
        return (i == 2) ? 4 : 0;
    endfunction

    function automatic logic [FRAME-1:0] mkframe(input logic [W-1:0] w);
`ifdef SHIFTER_SERIALIZER_PARITY_EN
        return {w, ^w};
`else
        return w;
`endif
    endfunction

    // Expected outputs in cycle c from the accept timeline alone.
    function automatic void expect_at(input int i, input int c, output logic r, output logic d,
                                      output logic v, output logic f, output logic l, output logic b);
        int k, dv, gp, span;
        dv = div_of(i);
        gp = gap_of(i);
        span = FRAME * dv;
        k = c - tacc[i] - 1;
        r = 1'b1; d = 1'b0; v = 1'b0; f = 1'b0; l = 1'b0; b = 1'b0;
        if (act[i] && k >= 0) begin
            if (k < span) begin
                b = 1'b1;
                v = (k % dv) == 0;
                d = frm[i][FRAME - 1 - k / dv];
                f = v && (k / dv == 0);
                l = v && (k / dv == FRAME - 1);
                r = (gp == 0) && (k == span - 1);
            end else if (k < span + gp) begin
                b = 1'b1;
                r = 1'b0;
            end
        end
    endfunction

    // Model advance on each edge.
    always @(posedge clk) begin
        for (int i = 0; i < ND; i++) begin
            logic r, d, v, f, l, b;
            expect_at(i, cyc, r, d, v, f, l, b);
            if (rst) act[i] <= 1'b0;
            else if (word_val && r) begin
                act[i]  <= 1'b1;
                tacc[i] <= cyc;
                frm[i]  <= mkframe(word);
            end
        end
        if (rst) chk_en <= 1'b1;
        cyc <= cyc + 1;
    end

    task automatic chk(input string name, input int i, input logic got, input logic want);
        n_checks++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s dut%0d cycle %0d: got %b want %b", name, i, cyc, got, want);
        end
    endtask

    // Compare process: model check every cycle plus literal expectations.
    always @(negedge clk) begin
        if (chk_en) begin
            logic [7:0] pat;
            pat = 8'hA5;
            for (int i = 0; i < ND; i++) begin
                logic r, d, v, f, l, b;
                expect_at(i, cyc, r, d, v, f, l, b);
                chk("rdy", i, rdy_o[i], r);
                chk("data", i, data_o[i], d);
                chk("val", i, val_o[i], v);
                chk("first", i, first_o[i], f);
                chk("last", i, last_o[i], l);
                chk("busy", i, busy_o[i], b);
            end
            if (cyc == 2) begin
                for (int i = 0; i < ND; i++) begin
                    chk("lit_rst_rdy", i, rdy_o[i], 1'b1);
                    chk("lit_rst_val", i, val_o[i], 1'b0);
                    chk("lit_rst_busy", i, busy_o[i], 1'b0);
                    chk("lit_rst_data", i, data_o[i], 1'b0);
                end
            end
            // Single 0xA5
            if (cyc == ta5 + 1) begin
                chk("lit_a5_first0", 0, first_o[0], 1'b1);
                chk("lit_a5_first1", 1, first_o[1], 1'b1);
            end
            if (cyc >= ta5 + 1 && cyc <= ta5 + 8) begin
                chk("lit_a5_val", 0, val_o[0], 1'b1);
                chk("lit_a5_data", 0, data_o[0], pat[7 - (cyc - ta5 - 1)]);
            end
`ifndef SHIFTER_SERIALIZER_PARITY_EN
            if (cyc == ta5 + 8) begin
                chk("lit_a5_last", 0, last_o[0], 1'b1);
                chk("lit_a5_rdy", 0, rdy_o[0], 1'b1);
                chk("lit_a5_gaprdy", 2, rdy_o[2], 1'b0);
            end
            if (cyc == ta5 + 22) begin
                chk("lit_div_val", 1, val_o[1], 1'b1);
                chk("lit_div_last", 1, last_o[1], 1'b1);
            end
            if (cyc == ta5 + 23) chk("lit_div_hold", 1, val_o[1], 1'b0);
            if (cyc == ta5 + 24) chk("lit_div_busy", 1, busy_o[1], 1'b1);
            if (cyc == ta5 + 25) chk("lit_div_idle", 1, busy_o[1], 1'b0);
            if (cyc == ta5 + 12) chk("lit_gap_busy", 2, busy_o[2], 1'b1);
            if (cyc == ta5 + 13) chk("lit_gap_rdy", 2, rdy_o[2], 1'b1);
            // Back-to-back 0xFF, 0x00
            if (cyc >= tbb + 1 && cyc <= tbb + 16) begin
                chk("lit_b2b_val", 0, val_o[0], 1'b1);
                chk("lit_b2b_data", 0, data_o[0], (cyc <= tbb + 8) ? 1'b1 : 1'b0);
                chk("lit_b2b_first", 0, first_o[0], (cyc == tbb + 1 || cyc == tbb + 9) ? 1'b1 : 1'b0);
                chk("lit_b2b_last", 0, last_o[0], (cyc == tbb + 8 || cyc == tbb + 16) ? 1'b1 : 1'b0);
            end
            if (cyc == tbb + 17) chk("lit_b2b_end", 0, val_o[0], 1'b0);
            // Held valid with GAP=4
            if (cyc >= tgp + 1 && cyc <= tgp + 12) chk("lit_gap_rdylow", 2, rdy_o[2], 1'b0);
            if (cyc == tgp + 13) chk("lit_gap_rdyhi", 2, rdy_o[2], 1'b1);
            if (cyc == tgp + 14) chk("lit_gap_first2", 2, first_o[2], 1'b1);
`endif
            // Reset mid-word
            if (cyc == tmr + 5 || cyc == tmr + 6) begin
                for (int i = 0; i < ND; i++) begin
                    chk("lit_mr_val", i, val_o[i], 1'b0);
                    chk("lit_mr_rdy", i, rdy_o[i], 1'b1);
                end
            end
            if (cyc == tmr + 7) begin
                chk("lit_mr_first", 0, first_o[0], 1'b1);
                chk("lit_mr_data", 0, data_o[0], 1'b0);
            end
`ifdef SHIFTER_SERIALIZER_PARITY_EN
            if (cyc == tpa + 8) chk("lit_par_notlast", 0, last_o[0], 1'b0);
            if (cyc == tpa + 9) begin
                chk("lit_par_val", 0, val_o[0], 1'b1);
                chk("lit_par_bit1", 0, data_o[0], 1'b1);
                chk("lit_par_last", 0, last_o[0], 1'b1);
            end
            if (cyc == tpb + 9) begin
                chk("lit_par_bit0", 0, data_o[0], 1'b0);
                chk("lit_par_last0", 0, last_o[0], 1'b1);
            end
`else
            if (cyc == tpa + 8) begin
                chk("lit_07_last", 0, last_o[0], 1'b1);
                chk("lit_07_data", 0, data_o[0], 1'b1);
            end
            if (cyc == tpb + 8) chk("lit_03_data", 0, data_o[0], 1'b1);
            if (cyc == tpb + 9) chk("lit_03_idle", 0, val_o[0], 1'b0);
`endif
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1;
        word_val = 1'b0;
        word = '0;
        repeat (4) tick();
        rst = 1'b0;
        repeat (2) tick();

        word = 8'hA5; word_val = 1'b1; ta5 = cyc;
        tick();
        word_val = 1'b0;
        repeat (40) tick();

        word = 8'hFF; word_val = 1'b1; tbb = cyc;
        tick();
        word = 8'h00;
        repeat (8) tick();
        word_val = 1'b0;
        repeat (40) tick();

        word_val = 1'b1; tgp = cyc;
        for (int n = 0; n < 30; n++) begin
            word = W'($urandom);
            tick();
        end
        word_val = 1'b0;
        repeat (40) tick();

        word = 8'hA5; word_val = 1'b1; tmr = cyc;
        tick();
        word_val = 1'b0;
        repeat (3) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        tick();
        word = 8'h5A; word_val = 1'b1;
        tick();
        word_val = 1'b0;
        repeat (40) tick();

        word = 8'h07; word_val = 1'b1; tpa = cyc;
        tick();
        word_val = 1'b0;
        repeat (30) tick();
        word = 8'h03; word_val = 1'b1; tpb = cyc;
        tick();
        word_val = 1'b0;
        repeat (30) tick();

        for (int n = 0; n < 3000; n++) begin
            rst = ($urandom_range(0, 199) == 0);
            word_val = ($urandom_range(0, 2) != 0);
            word = W'($urandom);
            tick();
        end
        rst = 1'b0;
        word_val = 1'b0;
        repeat (40) tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/shifter_serializer.md
Name: shifter_serializer

Overview:
- Parallel-to-serial transmitter. The opposite end of the team's bit-serial capture path.
- Accepts a WIDTH-bit word on a valid/ready handshake and shifts it out MSB first, one bit per bit period.
- Each bit is qualified by a data_val strobe, so an LSB-side shift-in receiver rebuilds the word in its original bit order.
- Used to drive serial links and to feed captured or generated words back into bit-serial debug logic.

Parameters:
- WIDTH, 32, word width in bits; legal range 2..256.
- DIV, 1, clock cycles per bit period; legal range 1..65535.
- GAP, 0, idle cycles inserted after each word before the next can be accepted; legal range 0..65535.

Ports:
- clk, input, 1, single clock; all logic on its rising edge.
- rst, input, 1, synchronous active-high reset.
- word_i, input, WIDTH, parallel word to transmit.
- word_val_i, input, 1, word_i valid.
- word_rdy_o, output, 1, block can accept a word this cycle.
- data_o, output, 1, serial bit, MSB first.
- data_val_o, output, 1, one-cycle strobe in the first cycle of each bit period.
- first_o, output, 1, coincides with data_val_o for the first bit of a word.
- last_o, output, 1, coincides with data_val_o for the final bit of a word.
- busy_o, output, 1, high in SHIFT or GAP.

Behaviour:
- Clock and reset: one clock (clk); reset (rst) is synchronous and active-high.
- Reset values: state=IDLE, word_rdy_o=1, data_o=0, data_val_o=0, first_o=0, last_o=0, busy_o=0, bit counter=0, divider=0, gap counter=0.
- Handshake:
  - Accept occurs on a clock edge where word_val_i && word_rdy_o.
  - word_i is captured into a shift register on that edge; later changes to word_i are ignored.
  - word_val_i while word_rdy_o=0 is ignored; nothing is queued or stored.
- State machine:
  - IDLE: word_rdy_o=1. On accept, go to SHIFT with bit counter=0 and divider=0.
  - SHIFT:
    - data_o = shift register MSB, held for exactly DIV cycles per bit.
    - data_val_o=1 only when divider==0.
    - When divider reaches DIV-1, shift left by one and increment the bit counter.
    - After the last bit's period: go to GAP if GAP>0, otherwise go to IDLE.
  - GAP: all strobes low, data_o=0. Stay GAP cycles, then go to IDLE.
- Back-to-back operation (GAP==0 only):
  - word_rdy_o is also high in the final cycle of the last bit period.
  - An accept on that edge goes directly to SHIFT with the new word. There are no idle cycles between words.
- Latency: the first data_val_o and first_o appear in the cycle after the accept edge (all outputs registered).
- Throughput:
  - WIDTH*DIV cycles per word when GAP==0 and traffic is back-to-back.
  - Otherwise WIDTH*DIV+GAP+1 cycles per word.
- Counter widths: bit counter sized by $clog2(WIDTH+1); divider and gap counters 16 bit. No wrap occurs within legal parameter ranges.
- DIV==1: data_val_o is continuously high for WIDTH cycles; first_o and last_o are each one cycle.
- data_o is 0 whenever data_val_o has not been asserted for the current bit period in IDLE or GAP.
- Reset mid-word:
  - The word in flight is abandoned. No further strobes are issued.
  - All outputs return to reset values on the same edge.
  - An accept on the reset edge is ignored.

Optional Feature:
- Macro: SHIFTER_SERIALIZER_PARITY_EN.
- Defined:
  - One extra bit period follows the WIDTH data bits, carrying the even-parity bit (XOR of the captured word).
  - last_o marks the parity bit, not data bit 0.
  - Frame is WIDTH+1 bits; throughput formulas use WIDTH+1.
  - Parity is computed at capture.
- Undefined: no parity logic; frame is exactly WIDTH bits.

Test Plan:
- WIDTH=8, DIV=1, GAP=0; accept 0xA5 at cycle 0 -> cycles 1..8 data_o=1,0,1,0,0,1,0,1 with data_val_o=1. first_o at cycle 1, last_o at cycle 8. word_rdy_o=1 at cycle 8.
- WIDTH=8, DIV=3; accept 0x81 -> data_val_o pulses at cycles 1,4,...,22. data_o held 3 cycles per bit. busy_o low at cycle 25.
- Back-to-back, GAP=0: present 0xFF then 0x00 with word_val_i held -> 16 contiguous data_val_o cycles. first_o at cycles 1 and 9, last_o at 8 and 16.
- GAP=4, WIDTH=8, DIV=1, word_val_i held -> word_rdy_o low for 8+4 cycles after each accept. Second first_o at cycle 14.
- Assert rst at cycle 4 during 0xA5 -> from cycle 5 data_val_o=0 and word_rdy_o=1. A word accepted at cycle 6 transmits from cycle 7 starting with first_o.
- PARITY_EN, WIDTH=8, word 0x07 -> 9 strobes. Ninth bit data_o=1 with last_o=1. For word 0x03 the ninth bit is 0.
